// File: rtl/sync_fifo_pkg.sv
// Shared core constants for the RISC16 data path FIFO.
package sync_fifo_pkg;

  // RISC16 data path word width
  localparam int DEFAULT_WORD_WIDTH = 16;
  // 16-entry FIFO by default
  localparam int DEFAULT_ADDR_WIDTH = 4;

endpackage

// File: rtl/sync_fifo_ram.sv
// SyncRam: single-clock storage array with a synchronous write port and an
// asynchronous read port. Contents are never reset.
module SyncRam
  import sync_fifo_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  gclk,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] WriteAddr,
  input  logic [WORD_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadAddr,
  output logic [WORD_WIDTH-1:0] ReadData
);

  logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write the addressed word on the rising edge when enabled.
  always_ff @(posedge gclk) begin
    if (WriteEnable) begin
      mem[WriteAddr] <= WriteData;
    end
  end

  // The read port is combinational; the FIFO registers it on pop.
  assign ReadData = mem[ReadAddr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with 1-cycle read latency, registered
// occupancy count and sticky overflow/underflow flags.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  gclk,
  input  logic                  nReset,
  input  logic                  PushEnable,
  input  logic [WORD_WIDTH-1:0] PushData,
  input  logic                  PopEnable,
  output logic [WORD_WIDTH-1:0] PopData,
  output logic                  PopValid,
  output logic                  Full,
  output logic                  Empty,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [WORD_WIDTH-1:0] ram_rdata;
  logic                  push_ok;
  logic                  pop_ok;

  // Flags come from the registered count only, never from this cycle's enables.
  assign Full    = (Count == DEPTH);
  assign Empty   = (Count == '0);
  assign push_ok = PushEnable & ~Full;
  assign pop_ok  = PopEnable & ~Empty;

  SyncRam #(
    .WORD_WIDTH (WORD_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .gclk        (gclk),
    .WriteEnable (push_ok),
    .WriteAddr   (wr_ptr),
    .WriteData   (PushData),
    .ReadAddr    (rd_ptr),
    .ReadData    (ram_rdata)
  );

  // Pointers, occupancy, sticky error flags and the read-valid pulse.
  always_ff @(posedge gclk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      Count     <= '0;
      PopValid  <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      PopValid <= pop_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
      if (PushEnable && Full) begin
        Overflow <= 1'b1;
      end
      if (PopEnable && Empty) begin
        Underflow <= 1'b1;
      end
    end
  end

  // Capture the read word only on an accepted pop so PopData holds otherwise.
  always_ff @(posedge gclk or negedge nReset) begin
    if (!nReset) begin
      PopData <= '0;
    end else if (pop_ok) begin
      PopData <= ram_rdata;
    end
  end

endmodule
